// File: rtl/uart_rx_packer_ctrl.sv
// UART receive drain controller: pops received characters, packs them into
// multi-lane words with per-lane error tags, and flushes partial words on
// line-idle timeout or break.
module uart_rx_packer_ctrl #(
    parameter int unsigned DATA_BITS      = 8,
    parameter int unsigned BYTES_PER_WORD = 4,
    parameter int unsigned TIMEOUT_TICKS  = 640
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          enable,
    input  logic                          tick_16x,
    input  logic                          rx_data_ready,
    input  logic [DATA_BITS-1:0]          rx_data,
    input  logic                          frame_error,
    input  logic                          parity_error,
    input  logic                          overrun_error,
    input  logic                          break_detect,
    output logic                          read_data,
    output logic                          clear_error,
    output logic [8*BYTES_PER_WORD-1:0]   word_data,
    output logic [2:0]                    word_bytes,
    output logic [BYTES_PER_WORD-1:0]     word_err,
    output logic                          word_valid,
    input  logic                          word_ready,
    output logic                          irq_timeout,
    output logic                          irq_break
);

    localparam int unsigned WORD_W = 8 * BYTES_PER_WORD;
    localparam int unsigned CNT_W  = $clog2(TIMEOUT_TICKS + 1);
    localparam logic [2:0]       LAST_IDX = 3'(BYTES_PER_WORD - 1);
    localparam logic [CNT_W-1:0] TO_MAX   = CNT_W'(TIMEOUT_TICKS);
    localparam logic [CNT_W-1:0] TO_PRE   = CNT_W'(TIMEOUT_TICKS - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_READ    = 2'd1,
        S_CAPTURE = 2'd2,
        S_EMIT    = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [2:0]         r_idx;
    logic [WORD_W-1:0]  r_word;
    logic [BYTES_PER_WORD-1:0] r_err;
    logic [CNT_W-1:0]   r_tcount;
    logic               r_flush_pending;
    logic               r_break_q;
    logic               r_read_data;
    logic               r_clear_error;
    logic               r_word_valid;
    logic               r_irq_timeout;
    logic               r_irq_break;

    logic w_err_any;
    logic w_break_rise;
    logic w_break_flush;
    logic w_tick_count;
    logic w_timeout_hit;
    logic w_flush;
    logic w_capture;
    logic w_accept;
    logic w_emit_entry;

    assign w_err_any     = frame_error | parity_error | overrun_error;
    assign w_break_rise  = break_detect & ~r_break_q;
    assign w_break_flush = w_break_rise && (r_idx != 3'd0);
    assign w_tick_count  = (r_state == S_IDLE) && (r_idx != 3'd0) && !rx_data_ready
                           && tick_16x && (r_tcount != TO_MAX);
    assign w_timeout_hit = w_tick_count && (r_tcount == TO_PRE);
    assign w_flush       = r_flush_pending | w_timeout_hit | w_break_flush;
    assign w_capture     = (r_state == S_CAPTURE);
    assign w_accept      = (r_state == S_EMIT) && word_ready;
    assign w_emit_entry  = (w_state_next == S_EMIT) && (r_state != S_EMIT);

    assign read_data   = r_read_data;
    assign clear_error = r_clear_error;
    assign word_data   = r_word;
    assign word_bytes  = r_idx;
    assign word_err    = r_err;
    assign word_valid  = r_word_valid;
    assign irq_timeout = r_irq_timeout;
    assign irq_break   = r_irq_break;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_next;
    end

    // Next-state decode; a pending flush outranks a new read
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_flush && (r_idx != 3'd0))
                    w_state_next = S_EMIT;
                else if (enable && rx_data_ready && !break_detect)
                    w_state_next = S_READ;
            end
            S_READ:    w_state_next = S_CAPTURE;
            S_CAPTURE: w_state_next = (r_idx == LAST_IDX) ? S_EMIT : S_IDLE;
            S_EMIT:    if (word_ready) w_state_next = S_IDLE;
            default:   w_state_next = S_IDLE;
        endcase
    end

    // Registered strobes, decoded from the upcoming state so they align with it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_read_data   <= 1'b0;
            r_clear_error <= 1'b0;
            r_word_valid  <= 1'b0;
            r_irq_timeout <= 1'b0;
            r_irq_break   <= 1'b0;
            r_break_q     <= 1'b0;
        end else begin
            r_read_data   <= (w_state_next == S_READ);
            r_clear_error <= (w_state_next == S_CAPTURE) && w_err_any;
            r_word_valid  <= (w_state_next == S_EMIT);
            r_irq_timeout <= w_timeout_hit;
            r_irq_break   <= w_break_rise;
            r_break_q     <= break_detect;
        end
    end

    // Lane packing and error tagging; cleared once the host takes the word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_word <= '0;
            r_err  <= '0;
            r_idx  <= 3'd0;
        end else if (w_capture) begin
            for (int i = 0; i < BYTES_PER_WORD; i++) begin
                if (r_idx == 3'(i)) begin
                    r_word[8*i +: 8] <= 8'(rx_data);
                    r_err[i]         <= w_err_any;
                end
            end
            r_idx <= r_idx + 3'd1;
        end else if (w_accept) begin
            r_word <= '0;
            r_err  <= '0;
            r_idx  <= 3'd0;
        end
    end

    // Line-idle counter, saturating, only while a partial word waits
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                     r_tcount <= '0;
        else if (w_capture || w_accept) r_tcount <= '0;
        else if (w_tick_count)          r_tcount <= r_tcount + CNT_W'(1);
    end

    // Flush request from timeout or break; consumed on entry to emit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_flush_pending <= 1'b0;
        else if (w_emit_entry)
            r_flush_pending <= 1'b0;
        else if ((w_timeout_hit || w_break_flush) && (r_state != S_EMIT))
            r_flush_pending <= 1'b1;
    end

endmodule
